alu_simd_pipelined: RTL

//  Two-stage pipelined SIMD ALU: next generation of the combinational W+X+Y+Z / logic ALU.

---
 rtl/alu_simd_pipelined_if.sv | 35 +++
 rtl/alu_simd_pipelined.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_simd_pipelined_if.sv
// Bundle/result handshake interface for alu_simd_pipelined.
// The master drives the operand bundle and out_ready.
// The slave (the ALU) drives in_ready and the result side.
interface alu_simd_pipelined_if #(
  parameter int WIDTH = 48,
  parameter int LANES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   W;
  logic [WIDTH-1:0]   X;
  logic [WIDTH-1:0]   Y;
  logic [WIDTH-1:0]   Z;
  logic [1:0]         op;
  logic [1:0]         simd_mode;
  logic               z_inv;
  logic               wxy_inv;
  logic               s_inv;
  logic               acc_en;
  logic [LANES-1:0]   cin;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   S;
  logic [2*LANES-1:0] cout;

  modport master (
    output in_valid, W, X, Y, Z, op, simd_mode, z_inv, wxy_inv, s_inv, acc_en, cin, out_ready,
    input  in_ready, out_valid, S, cout
  );

  modport slave (
    input  in_valid, W, X, Y, Z, op, simd_mode, z_inv, wxy_inv, s_inv, acc_en, cin, out_ready,
    output in_ready, out_valid, S, cout
  );
endinterface

// File: rtl/alu_simd_pipelined.sv
// Two-stage pipelined SIMD ALU.
// The datapath is split into four segments that are grouped into 1, 2 or 4 lanes.
// Stage 1 forms W+X+Y+cin per lane. Stage 2 adds Zc, applies the op mux and the inversions.
// Accumulate mode feeds the S register back in place of Z.
// Optional feature: define ALU_SIMD_SATURATE_EN to force an overflowing sum lane to all-ones.
module alu_simd_pipelined #(
  parameter int WIDTH = 48
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_simd_pipelined_if.slave bus
);
  localparam int LANES = 4;
  localparam int SEG   = WIDTH / LANES;

  typedef enum logic [1:0] {
    OP_SUM = 2'b00,
    OP_XOR = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  // Stage-1 payload. The lane layout travels as a decoded base-segment mask.
  typedef struct packed {
    logic [WIDTH-1:0]      t;
    logic [LANES-1:0][1:0] c1;
    logic [WIDTH-1:0]      x;
    logic [WIDTH-1:0]      y;
    logic [WIDTH-1:0]      z;
    op_e                   op;
    logic [LANES-1:0]      base;
    logic                  z_inv;
    logic                  wxy_inv;
    logic                  s_inv;
    logic                  acc_en;
  } s1_t;

  // Segments where a lane starts. The reserved mode 11 behaves as a single lane.
  function automatic logic [LANES-1:0] lane_base(input logic [1:0] mode);
    case (mode)
      2'b01:   return 4'b0101;
      2'b10:   return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  logic                 v1_q;
  s1_t                  s1_q, s1_d;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     s_q, s_d;
  logic [2*LANES-1:0]   cout_q, cout_d;
  logic                 adv;
  logic                 accept;

  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = !v1_q || adv;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.cout      = cout_q;

  // Stage 1: three-operand add per lane, segment ripple restarted at each lane base.
  always_comb begin
    logic [1:0]     c_a;
    logic [SEG+1:0] sum_a;
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    s1_d         = '0;
    c_a          = '0;
    sum_a        = '0;
    s1_d.base    = lane_base(bus.simd_mode);
    s1_d.x       = bus.X;
    s1_d.y       = bus.Y;
    s1_d.z       = bus.Z;
    s1_d.op      = op_e'(bus.op);
    s1_d.z_inv   = bus.z_inv;
    s1_d.wxy_inv = bus.wxy_inv;
    s1_d.s_inv   = bus.s_inv;
    s1_d.acc_en  = bus.acc_en;
    for (int k = 0; k < LANES; k++) begin
      if (s1_d.base[k]) c_a = {1'b0, bus.cin[k]};
      sum_a = (SEG+2)'(bus.W[k*SEG +: SEG]) + (SEG+2)'(bus.X[k*SEG +: SEG])
            + (SEG+2)'(bus.Y[k*SEG +: SEG]) + (SEG+2)'(c_a);
      s1_d.t[k*SEG +: SEG] = sum_a[SEG-1:0];
      c_a        = sum_a[SEG+1:SEG];
      s1_d.c1[k] = c_a;
    end
  end

  // Stage 2: add Zc per lane, select the op result, and build the per-lane carry counts.
  always_comb begin
    logic [WIDTH-1:0]      zc;
    logic [WIDTH-1:0]      tp;
    logic [WIDTH-1:0]      sum;
    logic [WIDTH-1:0]      mux;
    logic                  c_b;
    logic [SEG:0]          sum_b;
    logic [LANES-1:0]      top;
    logic [LANES-1:0][1:0] cnt;
    top   = {1'b1, s1_q.base[LANES-1:1]};
    zc    = (s1_q.acc_en ? s_q : s1_q.z) ^ {WIDTH{s1_q.z_inv}};
    tp    = s1_q.t ^ {WIDTH{s1_q.wxy_inv}};
    c_b   = 1'b0;
    sum   = '0;
    sum_b = '0;
    cnt   = '0;
    for (int k = 0; k < LANES; k++) begin
      if (s1_q.base[k]) c_b = 1'b0;
      sum_b = (SEG+1)'(tp[k*SEG +: SEG]) + (SEG+1)'(zc[k*SEG +: SEG]) + (SEG+1)'(c_b);
      sum[k*SEG +: SEG] = sum_b[SEG-1:0];
      c_b    = sum_b[SEG];
      cnt[k] = s1_q.c1[k] + {1'b0, c_b};
    end
`ifdef ALU_SIMD_SATURATE_EN
    begin
      logic sat;
      // Walk down from each lane's top segment so the whole lane shares its overflow flag.
      sat = 1'b0;
      for (int k = LANES-1; k >= 0; k--) begin
        if (top[k]) sat = (cnt[k] != 2'b00);
        if (sat) sum[k*SEG +: SEG] = '1;
      end
    end
`else
    // Wrap-around: each lane keeps its modulo result and overflow shows only on cout.
`endif
    mux = sum;
    case (s1_q.op)
      OP_SUM:  mux = sum;
      OP_XOR:  mux = s1_q.x ^ zc ^ s1_q.y;
      OP_AND:  mux = s1_q.x & zc;
      default: mux = s1_q.x | zc;
    endcase
    s_d    = mux ^ {WIDTH{s1_q.s_inv}};
    cout_d = '0;
    for (int k = 0; k < LANES; k++) begin
      if (top[k] && s1_q.op == OP_SUM) cout_d[2*k +: 2] = cnt[k];
    end
  end

  // Stage-1 register: load on transfer, drain when the bundle moves into stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset too, because S feeds back as an operand and the
    // outputs must read zero right after reset.
    if (!rst_n) begin
      v1_q <= 1'b0;
      s1_q <= '0;
    end else if (accept) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      v1_q <= 1'b1;
      s1_q <= s1_d;
    end else if (adv) begin
      v1_q <= 1'b0;
    end
  end

  // Output register: S, cout and out_valid advance together and hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= '0;
    end else if (adv) begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        s_q    <= s_d;
        cout_q <= cout_d;
      end
    end
  end
endmodule
